// File: rtl/frame_stream_display_pkg.sv
// Shared definitions for the framebuffer-to-LCD stream path.
//   state_e            : sequencer states of frame_stream_display
//   LCD_CMD_RAMWR      : panel memory-write command sent ahead of every frame
//   pixels_per_beat    : 16-bit pixels carried by one stream beat
//   beats_per_frame    : expected beat count for a full frame
//   rgba4444_to_rgb565 : pixel format conversion (alpha dropped)
package frame_stream_display_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LOAD,
    ST_PIX,
    ST_END
  } state_e;

  localparam logic [7:0] LCD_CMD_RAMWR = 8'h2C;

  function automatic int unsigned pixels_per_beat(input int unsigned stream_width);
    return stream_width / 16;
  endfunction

  function automatic int unsigned beats_per_frame(input int unsigned frame_size,
                                                  input int unsigned stream_width);
    return frame_size / pixels_per_beat(stream_width);
  endfunction

  // Widen each channel by replicating its top bits so full scale maps to full scale.
  function automatic logic [15:0] rgba4444_to_rgb565(input logic [15:0] px);
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    r = px[15:12];
    g = px[11:8];
    b = px[7:4];
    return {r, r[3], g, g[3:2], b, b[3]};
  endfunction

endpackage

// File: rtl/frame_stream_display_lcd_byte_writer.sv
// One 8080-style bus write per start pulse.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   start_i       : launch a byte cycle (accepted at any time, also on done_o)
//   byte_i, dc_i  : byte and data/command flag for the launched cycle
//   lcd_data_o    : bus data, held until the next start
//   lcd_dc_o      : 0 = command, 1 = data
//   lcd_wrn_o     : low for WR_CYCLES clocks, then high for WR_CYCLES clocks
//   busy_o        : a byte cycle is in progress
//   done_o        : last clock of the byte cycle; a start here chains seamlessly
module lcd_byte_writer
  import frame_stream_display_pkg::*;
#(
  parameter int unsigned WR_CYCLES = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  input  logic       dc_i,
  output logic [7:0] lcd_data_o,
  output logic       lcd_dc_o,
  output logic       lcd_wrn_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int unsigned CW = $clog2(2 * WR_CYCLES);

  logic [7:0]    data_q, data_d;
  logic          dc_q, dc_d;
  logic          wrn_q, wrn_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign done_o     = busy_q && (cnt_q == CW'(2 * WR_CYCLES - 1));
  assign busy_o     = busy_q;
  assign lcd_data_o = data_q;
  assign lcd_dc_o   = dc_q;
  assign lcd_wrn_o  = wrn_q;

  always_comb begin
    data_d = data_q;
    dc_d   = dc_q;
    wrn_d  = wrn_q;
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (start_i) begin
      data_d = byte_i;
      dc_d   = dc_i;
      wrn_d  = 1'b0;
      busy_d = 1'b1;
      cnt_d  = '0;
    end else if (busy_q) begin
      if (done_o) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WR_CYCLES - 1)) begin
          wrn_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      dc_q   <= 1'b1;
      wrn_q  <= 1'b1;
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      dc_q   <= dc_d;
      wrn_q  <= wrn_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/frame_stream_display.sv
// AXI Stream (RGBA4444) to 8-bit 8080 LCD write bus bridge.
//   clk, resetn      : clock, asynchronous active-low reset
//   s_axis_*         : framebuffer commit stream, pixel 0 in tdata[15:0]
//   lcd_data, lcd_dc : bus byte and data/command flag
//   lcd_wrn, lcd_csn : write strobe and chip select, both active low
//   frame_done       : one-cycle pulse at the end of every frame
//   frame_error      : with frame_done when tlast did not line up with FRAME_SIZE
module frame_stream_display
  import frame_stream_display_pkg::*;
#(
  parameter int unsigned FRAME_SIZE   = 128 * 128,
  parameter int unsigned STREAM_WIDTH = 16,
  parameter int unsigned WR_CYCLES    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [STREAM_WIDTH-1:0] s_axis_tdata,
  output logic [7:0]              lcd_data,
  output logic                    lcd_dc,
  output logic                    lcd_wrn,
  output logic                    lcd_csn,
  output logic                    frame_done,
  output logic                    frame_error
);

  localparam int unsigned PPB    = pixels_per_beat(STREAM_WIDTH);
  localparam int unsigned BEATS  = beats_per_frame(FRAME_SIZE, STREAM_WIDTH);
  localparam int unsigned BCW    = $clog2(BEATS + 1);
  localparam int unsigned NBYTES = 2 * PPB;
  localparam int unsigned IW     = $clog2(NBYTES + 1);

  state_e                  state_q, state_d;
  logic [BCW-1:0]          beat_cnt_q, beat_cnt_d;
  logic [STREAM_WIDTH-1:0] data_q, data_d;
  logic                    last_q, last_d;
  logic [IW-1:0]           idx_q, idx_d;

  logic                    wr_start, wr_dc, wr_busy, wr_done;
  logic [7:0]              wr_byte;

  logic [STREAM_WIDTH-1:0] src_data;
  logic [IW-1:0]           src_idx;
  logic [15:0]             src_pix;
  logic [15:0]             src_565;
  logic [7:0]              src_byte;
  logic                    cnt_full;

  // The first pixel byte is launched on the accepting LOAD cycle straight from
  // the bus, so a beat costs one LOAD clock plus its byte cycles and no more.
  always_comb begin
    src_data = (state_q == ST_LOAD) ? s_axis_tdata : data_q;
    src_idx  = (state_q == ST_LOAD) ? '0 : idx_q;
    src_pix  = '0;
    for (int unsigned p = 0; p < PPB; p++) begin
      if (IW'(p) == (src_idx >> 1)) begin
        src_pix = src_data[16*p +: 16];
      end
    end
    src_565  = rgba4444_to_rgb565(src_pix);
    src_byte = src_idx[0] ? src_565[7:0] : src_565[15:8];
  end

  assign cnt_full = (beat_cnt_q == BCW'(BEATS));

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    data_d     = data_q;
    last_d     = last_q;
    idx_d      = idx_q;
    wr_start   = 1'b0;
    wr_byte    = src_byte;
    wr_dc      = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (s_axis_tvalid) begin
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        wr_dc    = 1'b0;
        wr_byte  = LCD_CMD_RAMWR;
        wr_start = !wr_busy;
        if (wr_done) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (s_axis_tvalid) begin
          data_d     = s_axis_tdata;
          last_d     = s_axis_tlast;
          beat_cnt_d = beat_cnt_q + BCW'(1);
          idx_d      = IW'(1);
          wr_start   = 1'b1;
          state_d    = ST_PIX;
        end
      end
      ST_PIX: begin
        if (wr_done) begin
          if (idx_q == IW'(NBYTES)) begin
            state_d = (last_q || cnt_full) ? ST_END : ST_LOAD;
          end else begin
            wr_start = 1'b1;
            idx_d    = idx_q + IW'(1);
          end
        end
      end
      ST_END: begin
        beat_cnt_d = '0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      data_q     <= data_d;
      last_q     <= last_d;
      idx_q      <= idx_d;
    end
  end

  lcd_byte_writer #(
    .WR_CYCLES(WR_CYCLES)
  ) u_writer (
    .clk_i     (clk),
    .rst_ni    (resetn),
    .start_i   (wr_start),
    .byte_i    (wr_byte),
    .dc_i      (wr_dc),
    .lcd_data_o(lcd_data),
    .lcd_dc_o  (lcd_dc),
    .lcd_wrn_o (lcd_wrn),
    .busy_o    (wr_busy),
    .done_o    (wr_done)
  );

  assign s_axis_tready = (state_q == ST_LOAD);
  assign lcd_csn       = !(state_q inside {ST_CMD, ST_LOAD, ST_PIX});
  assign frame_done    = (state_q == ST_END);
  // Error when exactly one of "tlast seen" and "expected count reached" holds.
  assign frame_error   = (state_q == ST_END) && (last_q ^ cnt_full);

endmodule

// File: tb/tb_frame_stream_display.sv
module tb_frame_stream_display;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // DUT A: FRAME_SIZE=4, 16-bit stream, WR_CYCLES=1
  logic        a_tvalid, a_tready, a_tlast;
  logic [15:0] a_tdata;
  logic [7:0]  a_data;
  logic        a_dc, a_wrn, a_csn, a_done, a_err;

  // DUT B: FRAME_SIZE=4, 32-bit stream, WR_CYCLES=2
  logic        b_tvalid, b_tready, b_tlast;
  logic [31:0] b_tdata;
  logic [7:0]  b_data;
  logic        b_dc, b_wrn, b_csn, b_done, b_err;

  frame_stream_display #(.FRAME_SIZE(4), .STREAM_WIDTH(16), .WR_CYCLES(1)) u_dut_a (
    .clk(clk), .resetn(resetn),
    .s_axis_tvalid(a_tvalid), .s_axis_tready(a_tready), .s_axis_tlast(a_tlast),
    .s_axis_tdata(a_tdata),
    .lcd_data(a_data), .lcd_dc(a_dc), .lcd_wrn(a_wrn), .lcd_csn(a_csn),
    .frame_done(a_done), .frame_error(a_err)
  );

  frame_stream_display #(.FRAME_SIZE(4), .STREAM_WIDTH(32), .WR_CYCLES(2)) u_dut_b (
    .clk(clk), .resetn(resetn),
    .s_axis_tvalid(b_tvalid), .s_axis_tready(b_tready), .s_axis_tlast(b_tlast),
    .s_axis_tdata(b_tdata),
    .lcd_data(b_data), .lcd_dc(b_dc), .lcd_wrn(b_wrn), .lcd_csn(b_csn),
    .frame_done(b_done), .frame_error(b_err)
  );

  // Bus monitors: log {wrn low length, dc, data} at each wrn rising edge.
  logic [16:0] a_log  [0:1023];
  int          a_fcyc [0:1023];
  int          a_nb = 0, a_low = 0, a_fall = 0, a_done_n = 0, a_err_n = 0, a_orphan = 0, a_tr_n = 0;
  logic        a_wrn_prev = 1'b1;

  always @(negedge clk) begin
    if (!a_wrn) begin
      if (a_wrn_prev) a_fall = cyc;
      a_low++;
    end else if (!a_wrn_prev) begin
      a_log[a_nb % 1024]  = {a_low[7:0], a_dc, a_data};
      a_fcyc[a_nb % 1024] = a_fall;
      a_nb++;
      a_low = 0;
    end
    a_wrn_prev = a_wrn;
    if (a_done) a_done_n++;
    if (a_err) a_err_n++;
    if (a_err && !a_done) a_orphan++;
    if (a_tready) a_tr_n++;
  end

  logic [16:0] b_log  [0:1023];
  int          b_fcyc [0:1023];
  int          b_nb = 0, b_low = 0, b_fall = 0, b_done_n = 0, b_err_n = 0, b_orphan = 0, b_tr_n = 0;
  logic        b_wrn_prev = 1'b1;

  always @(negedge clk) begin
    if (!b_wrn) begin
      if (b_wrn_prev) b_fall = cyc;
      b_low++;
    end else if (!b_wrn_prev) begin
      b_log[b_nb % 1024]  = {b_low[7:0], b_dc, b_data};
      b_fcyc[b_nb % 1024] = b_fall;
      b_nb++;
      b_low = 0;
    end
    b_wrn_prev = b_wrn;
    if (b_done) b_done_n++;
    if (b_err) b_err_n++;
    if (b_err && !b_done) b_orphan++;
    if (b_tready) b_tr_n++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model565(input logic [15:0] p);
    int r, g, b;
    r = int'(p[15:12]);
    g = int'(p[11:8]);
    b = int'(p[7:4]);
    return 16'((((r * 2) + (r / 8)) << 11) | (((g * 4) + (g / 4)) << 5) | ((b * 2) + (b / 8)));
  endfunction

  task automatic check_bytes(input string tag, input logic [16:0] lg[0:1023], input int nb,
                             input int base, input logic [8:0] exp[$], input int wr);
    check_eq({tag, "_count"}, 32'(nb - base), 32'(exp.size()));
    for (int i = 0; i < exp.size() && base + i < nb; i++) begin
      check_eq($sformatf("%s_byte%0d", tag, i), 32'(lg[(base + i) % 1024][8:0]), 32'(exp[i]));
      check_eq($sformatf("%s_low%0d", tag, i), 32'(lg[(base + i) % 1024][16:9]), 32'(wr));
    end
  endtask

  int a_acc = 0, b_acc = 0;

  task automatic send_a(input logic [15:0] d, input logic last);
    bit ok;
    ok = 1'b0;
    a_tdata  = d;
    a_tlast  = last;
    a_tvalid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (a_tready) begin
        @(posedge clk);
        #1;
        a_acc = cyc;
        ok    = 1'b1;
      end
    end
    a_tvalid = 1'b0;
    a_tdata  = 16'hDEAD;
    a_tlast  = 1'b1;
    check_eq("a_beat_accepted", 32'(ok), 32'd1);
  endtask

  task automatic send_b(input logic [31:0] d, input logic last);
    bit ok;
    ok = 1'b0;
    b_tdata  = d;
    b_tlast  = last;
    b_tvalid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (b_tready) begin
        @(posedge clk);
        #1;
        b_acc = cyc;
        ok    = 1'b1;
      end
    end
    b_tvalid = 1'b0;
    b_tdata  = 32'hDEADBEEF;
    b_tlast  = 1'b1;
    check_eq("b_beat_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input bit use_b, input int base, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = use_b ? (b_done_n > base) : (a_done_n > base);
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  logic [15:0] beats4 [4];
  logic [8:0]  e[$];
  logic [8:0]  frame_exp[$];
  int          base, db, eb, tb, t0, acc1;

  initial begin
    beats4[0] = 16'hF00F; beats4[1] = 16'h0F0F; beats4[2] = 16'h00FF; beats4[3] = 16'hFFFF;
    frame_exp = '{9'h02C, 9'h1F8, 9'h100, 9'h107, 9'h1E0, 9'h100, 9'h11F, 9'h1FF, 9'h1FF};

    a_tvalid = 1'b0; a_tlast = 1'b0; a_tdata = '0;
    b_tvalid = 1'b0; b_tlast = 1'b0; b_tdata = '0;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_csn",   32'(a_csn),    32'd1);
    check_eq("rst_wrn",   32'(a_wrn),    32'd1);
    check_eq("rst_dc",    32'(a_dc),     32'd1);
    check_eq("rst_data",  32'(a_data),   32'd0);
    check_eq("rst_tready",32'(a_tready), 32'd0);
    check_eq("rst_done",  32'(a_done),   32'd0);
    check_eq("rst_err",   32'(a_err),    32'd0);
    check_eq("rst_b_csn", 32'(b_csn),    32'd1);
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Full frame, tlast on beat 4
    base = a_nb; db = a_done_n; eb = a_err_n; tb = a_tr_n; t0 = cyc;
    send_a(beats4[0], 1'b0);
    acc1 = a_acc;
    send_a(beats4[1], 1'b0);
    check_eq("a_beat_period", 32'(a_acc - acc1), 32'd5);
    send_a(beats4[2], 1'b0);
    send_a(beats4[3], 1'b1);
    wait_done(1'b0, db, "full");
    check_eq("full_latency", 32'(a_fcyc[base % 1024] - t0), 32'd2);
    check_bytes("full", a_log, a_nb, base, frame_exp, 1);
    check_eq("full_done_cnt",   32'(a_done_n - db), 32'd1);
    check_eq("full_err_cnt",    32'(a_err_n - eb),  32'd0);
    check_eq("full_tready_cyc", 32'(a_tr_n - tb),   32'd4);
    check_eq("full_csn_idle",   32'(a_csn),         32'd1);

    // Early tlast on beat 2, then a lone third beat opens a new frame
    base = a_nb; db = a_done_n; eb = a_err_n;
    send_a(beats4[0], 1'b0);
    send_a(beats4[1], 1'b1);
    wait_done(1'b0, db, "early");
    check_eq("early_done_cnt", 32'(a_done_n - db), 32'd1);
    check_eq("early_err_cnt",  32'(a_err_n - eb),  32'd1);
    send_a(beats4[2], 1'b1);
    wait_done(1'b0, db + 1, "early3");
    e = '{9'h02C, 9'h1F8, 9'h100, 9'h107, 9'h1E0, 9'h02C, 9'h100, 9'h11F};
    check_bytes("early", a_log, a_nb, base, e, 1);

    // No tlast: ends at beat 4 with error; beat 5 starts a fresh frame
    base = a_nb; db = a_done_n; eb = a_err_n;
    for (int i = 0; i < 4; i++) send_a(beats4[i], 1'b0);
    wait_done(1'b0, db, "notlast");
    check_eq("notlast_err_cnt", 32'(a_err_n - eb), 32'd1);
    for (int i = 0; i < 4; i++) send_a(beats4[i], (i == 3));
    wait_done(1'b0, db + 1, "notlast2");
    e.delete();
    for (int k = 0; k < 2; k++) foreach (frame_exp[j]) e.push_back(frame_exp[j]);
    check_bytes("notlast", a_log, a_nb, base, e, 1);
    check_eq("notlast_done_cnt", 32'(a_done_n - db), 32'd2);
    check_eq("notlast_err_tot",  32'(a_err_n - eb),  32'd1);

    // Reset during PIX
    db = a_done_n;
    send_a(beats4[0], 1'b0);
    resetn = 1'b0;
    #1;
    check_eq("midrst_csn",    32'(a_csn),    32'd1);
    check_eq("midrst_wrn",    32'(a_wrn),    32'd1);
    check_eq("midrst_dc",     32'(a_dc),     32'd1);
    check_eq("midrst_data",   32'(a_data),   32'd0);
    check_eq("midrst_tready", 32'(a_tready), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_eq("midrst_no_done", 32'(a_done_n - db), 32'd0);
    base = a_nb; eb = a_err_n;
    for (int i = 0; i < 4; i++) send_a(beats4[i], (i == 3));
    wait_done(1'b0, db, "midrst");
    check_bytes("midrst", a_log, a_nb, base, frame_exp, 1);
    check_eq("midrst_err_cnt", 32'(a_err_n - eb), 32'd0);

    // Two pixels per beat, WR_CYCLES=2
    base = b_nb; db = b_done_n; eb = b_err_n; tb = b_tr_n; t0 = cyc;
    send_b(32'h0F0FF00F, 1'b0);
    acc1 = b_acc;
    send_b(32'hFFFF00FF, 1'b1);
    check_eq("b_beat_period", 32'(b_acc - acc1), 32'd17);
    wait_done(1'b1, db, "wide");
    check_bytes("wide", b_log, b_nb, base, frame_exp, 2);
    check_eq("wide_latency",     32'(b_fcyc[base % 1024] - t0), 32'd2);
    check_eq("wide_byte_period", 32'(b_fcyc[(base + 2) % 1024] - b_fcyc[(base + 1) % 1024]), 32'd4);
    check_eq("wide_done_cnt",    32'(b_done_n - db), 32'd1);
    check_eq("wide_err_cnt",     32'(b_err_n - eb),  32'd0);
    check_eq("wide_tready_cyc",  32'(b_tr_n - tb),   32'd2);

    // Random data with random valid gaps over several frames
    base = a_nb; db = a_done_n; eb = a_err_n;
    e.delete();
    for (int f = 0; f < 3; f++) begin
      e.push_back(9'h02C);
      for (int i = 0; i < 4; i++) begin
        logic [15:0] d;
        logic [15:0] m;
        d = 16'($urandom);
        m = model565(d);
        e.push_back({1'b1, m[15:8]});
        e.push_back({1'b1, m[7:0]});
        repeat ($urandom_range(0, 5)) begin
          @(posedge clk);
          #1;
        end
        send_a(d, (i == 3));
      end
      wait_done(1'b0, db + f, "gap");
    end
    check_bytes("gap", a_log, a_nb, base, e, 1);
    check_eq("gap_done_cnt", 32'(a_done_n - db), 32'd3);
    check_eq("gap_err_cnt",  32'(a_err_n - eb),  32'd0);

    check_eq("a_err_without_done", 32'(a_orphan), 32'd0);
    check_eq("b_err_without_done", 32'(b_orphan), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
